// File: rtl/param_fixed_divider.sv
// Sequential fixed-point divider: q = (A << FRAC_BITS) / B by restoring division,
// one quotient bit per clock, with divide-by-zero and saturating overflow flags.
module param_fixed_divider #(
  parameter int WIDTH     = 10,
  parameter int FRAC_BITS = 4,
  parameter int SIGNED    = 0
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             start,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             valid,
  output logic             ovf,
  output logic             dvz,
  output logic             busy,
  output logic [WIDTH-1:0] q
);

  localparam int N  = WIDTH + FRAC_BITS;
  localparam int CW = $clog2(N + 1);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
  localparam logic [N-1:0]     MAX_NEG = N'(1) << (WIDTH - 1);
  localparam logic [N-1:0]     MAX_POS = MAX_NEG - N'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [N-1:0]     dq_reg, dq_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             sign_reg, sign_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             ovf_reg, ovf_next;
  logic             dvz_reg, dvz_next;

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_shift;
  logic             ge;
  logic [WIDTH-1:0] diff;
  logic [N-1:0]     dq_iter;
  logic [WIDTH-1:0] res_q;
  logic             res_ovf;

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rem_reg   <= '0;
      dq_reg    <= '0;
      b_reg     <= '0;
      sign_reg  <= 1'b0;
      q_reg     <= '0;
      ovf_reg   <= 1'b0;
      dvz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rem_reg   <= rem_next;
      dq_reg    <= dq_next;
      b_reg     <= b_next;
      sign_reg  <= sign_next;
      q_reg     <= q_next;
      ovf_reg   <= ovf_next;
      dvz_reg   <= dvz_next;
    end
  end

  // Magnitudes are W-bit unsigned so that -2^(W-1) maps to 2^(W-1) exactly.
  always_comb begin
    neg_a = (SIGNED != 0) && data_a[WIDTH-1];
    neg_b = (SIGNED != 0) && data_b[WIDTH-1];
    a_mag = neg_a ? (~data_a + ONE_W) : data_a;
    b_mag = neg_b ? (~data_b + ONE_W) : data_b;
  end

  // One restoring step. The remainder stays below the divisor, so when the
  // subtraction succeeds its low W bits are the exact new remainder.
  always_comb begin
    rem_shift = {rem_reg, dq_reg[N-1]};
    ge        = rem_shift >= {1'b0, b_reg};
    diff      = rem_shift[WIDTH-1:0] - b_reg;
    dq_iter   = {dq_reg[N-2:0], ge};
  end

  always_comb begin
    res_ovf = 1'b0;
    res_q   = dq_iter[WIDTH-1:0];
    if (SIGNED == 0) begin
      if ((dq_iter >> WIDTH) != '0) begin
        res_ovf = 1'b1;
        res_q   = '1;
      end
    end else if (sign_reg) begin
      if (dq_iter > MAX_NEG) begin
        res_ovf = 1'b1;
        res_q   = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        res_q = ~dq_iter[WIDTH-1:0] + ONE_W;
      end
    end else if (dq_iter > MAX_POS) begin
      res_ovf = 1'b1;
      res_q   = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rem_next   = rem_reg;
    dq_next    = dq_reg;
    b_next     = b_reg;
    sign_next  = sign_reg;
    q_next     = q_reg;
    ovf_next   = ovf_reg;
    dvz_next   = dvz_reg;
    case (state_reg)
      RUN: begin
        rem_next = ge ? diff : rem_shift[WIDTH-1:0];
        dq_next  = dq_iter;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == CW'(N - 1)) begin
          state_next = DONE;
          q_next     = res_q;
          ovf_next   = res_ovf;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE falls back to IDLE otherwise.
        state_next = IDLE;
        if (start) begin
          ovf_next = 1'b0;
          dvz_next = 1'b0;
          if (data_b == '0) begin
            state_next = DONE;
            dvz_next   = 1'b1;
            q_next     = '0;
          end else begin
            state_next = RUN;
            cnt_next   = '0;
            rem_next   = '0;
            dq_next    = N'(a_mag) << FRAC_BITS;
            b_next     = b_mag;
            sign_next  = neg_a ^ neg_b;
          end
        end
      end
    endcase
  end

  assign valid = (state_reg == DONE);
  assign busy  = (state_reg == RUN);
  assign q     = q_reg;
  assign ovf   = ovf_reg;
  assign dvz   = dvz_reg;

endmodule

// File: tb/tb_param_fixed_divider.sv
// Bench for param_fixed_divider: an unsigned and a signed instance checked against
// an arithmetic reference model with directed and randomized operations.
module tb_param_fixed_divider;
  localparam int W = 10;
  localparam int F = 4;
  localparam int N = W + F;

  logic         clk = 1'b0;
  logic         sclr, start_u, start_s;
  logic [W-1:0] data_a, data_b;
  logic         valid_u, ovf_u, dvz_u, busy_u;
  logic         valid_s, ovf_s, dvz_s, busy_s;
  logic [W-1:0] q_u, q_s;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  param_fixed_divider #(.WIDTH(W), .FRAC_BITS(F), .SIGNED(0)) dut_u (
    .clk(clk), .sclr(sclr), .start(start_u), .data_a(data_a), .data_b(data_b),
    .valid(valid_u), .ovf(ovf_u), .dvz(dvz_u), .busy(busy_u), .q(q_u));

  param_fixed_divider #(.WIDTH(W), .FRAC_BITS(F), .SIGNED(1)) dut_s (
    .clk(clk), .sclr(sclr), .start(start_s), .data_a(data_a), .data_b(data_b),
    .valid(valid_s), .ovf(ovf_s), .dvz(dvz_s), .busy(busy_s), .q(q_s));

  // Reference: exact integer arithmetic on the real operand values.
  function automatic void model(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic ovf, output logic dvz);
    longint av, bv, mag;
    bit neg;
    q = '0; ovf = 1'b0; dvz = 1'b0;
    if (b == '0) begin
      dvz = 1'b1;
      return;
    end
    if (sgn) begin av = $signed(a); bv = $signed(b); end
    else begin av = a; bv = b; end
    neg = (av < 0) != (bv < 0);
    mag = ((av < 0 ? -av : av) * (64'sd1 << F)) / (bv < 0 ? -bv : bv);
    if (!sgn) begin
      if (mag >= (64'sd1 << W)) begin ovf = 1'b1; q = '1; end
      else q = W'(mag);
    end else if (!neg) begin
      if (mag > (64'sd1 << (W-1)) - 1) begin ovf = 1'b1; q = W'((64'sd1 << (W-1)) - 1); end
      else q = W'(mag);
    end else begin
      if (mag > (64'sd1 << (W-1))) begin ovf = 1'b1; q = W'(64'sd1 << (W-1)); end
      else q = W'(-mag);
    end
  endfunction

  // Issue one request and wait (bounded) for valid. poke_at > 0 re-pulses start
  // with unrelated data at that busy cycle, which the design must ignore.
  task automatic do_op(input bit sgn, input bit immediate, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int poke_at,
                       output logic [W-1:0] q, output logic ovf, output logic dvz,
                       output int lat, output int busy_cnt);
    if (!immediate) begin @(posedge clk); #1; end
    data_a = a; data_b = b;
    if (sgn) start_s = 1'b1; else start_u = 1'b1;
    @(posedge clk); #1;
    start_u = 1'b0; start_s = 1'b0;
    data_a = W'($urandom); data_b = W'($urandom);
    lat = 1; busy_cnt = 0;
    while (1) begin
      if (sgn ? busy_s : busy_u) busy_cnt++;
      if (sgn ? valid_s : valid_u) break;
      if (lat >= 100) break;
      if (lat == poke_at) begin
        data_a = W'($urandom); data_b = W'($urandom);
        if (sgn) start_s = 1'b1; else start_u = 1'b1;
      end else begin
        start_u = 1'b0; start_s = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start_u = 1'b0; start_s = 1'b0;
    q = sgn ? q_s : q_u; ovf = sgn ? ovf_s : ovf_u; dvz = sgn ? dvz_s : dvz_u;
  endtask

  task automatic check_op(input string name, input bit sgn, input bit immediate,
                          input logic [W-1:0] a, input logic [W-1:0] b, input int poke_at);
    logic [W-1:0] q, eq;
    logic ovf, dvz, eovf, edvz;
    int lat, bc;
    model(sgn, a, b, eq, eovf, edvz);
    do_op(sgn, immediate, a, b, poke_at, q, ovf, dvz, lat, bc);
    n_cmp++;
    if ({q, ovf, dvz} !== {eq, eovf, edvz}) begin
      n_fail++;
      $display("FAIL %s result a=%h b=%h: got q=%h ovf=%b dvz=%b, expected q=%h ovf=%b dvz=%b",
               name, a, b, q, ovf, dvz, eq, eovf, edvz);
    end
    n_cmp++;
    if (lat !== (edvz ? 1 : N + 1) || bc !== (edvz ? 0 : N)) begin
      n_fail++;
      $display("FAIL %s timing a=%h b=%h: got latency=%0d busy=%0d, expected latency=%0d busy=%0d",
               name, a, b, lat, bc, edvz ? 1 : N + 1, edvz ? 0 : N);
    end
    $display("%s sgn=%0d a=%h b=%h -> q=%h ovf=%b dvz=%b lat=%0d", name, sgn, a, b, q, ovf, dvz, lat);
  endtask

  task automatic test_reset();
    sclr = 1'b1; start_u = 1'b1; start_s = 1'b1; data_a = 10'h090; data_b = 10'h030;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy_u, valid_u, ovf_u, dvz_u, q_u} !== '0) begin
      n_fail++;
      $display("FAIL reset_u: got busy=%b valid=%b ovf=%b dvz=%b q=%h, expected all zero",
               busy_u, valid_u, ovf_u, dvz_u, q_u);
    end
    n_cmp++;
    if ({busy_s, valid_s, ovf_s, dvz_s, q_s} !== '0) begin
      n_fail++;
      $display("FAIL reset_s: got busy=%b valid=%b ovf=%b dvz=%b q=%h, expected all zero",
               busy_s, valid_s, ovf_s, dvz_s, q_s);
    end
    start_u = 1'b0; start_s = 1'b0; sclr = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_directed();
    check_op("normal", 1'b0, 1'b0, 10'h090, 10'h030, 0);
    check_op("div_zero", 1'b0, 1'b0, 10'h100, 10'h000, 0);
    check_op("overflow", 1'b0, 1'b0, 10'h3FF, 10'h001, 0);
    check_op("fraction", 1'b0, 1'b0, 10'h008, 10'h048, 0);
    check_op("ignored_start", 1'b0, 1'b0, 10'h090, 10'h030, 3);
  endtask

  task automatic test_signed();
    check_op("signed_neg", 1'b1, 1'b0, 10'h3A0, 10'h030, 0);
    check_op("signed_ovf_pos", 1'b1, 1'b0, 10'h200, 10'h3F0, 0);
    check_op("signed_min_exact", 1'b1, 1'b0, 10'h3F0, 10'h0F0, 0);
    check_op("signed_zero_q", 1'b1, 1'b0, 10'h000, 10'h3F0, 0);
    check_op("signed_dvz", 1'b1, 1'b0, 10'h200, 10'h000, 0);
  endtask

  task automatic test_abort();
    int seen = 0;
    @(posedge clk); #1;
    data_a = 10'h090; data_b = 10'h030; start_u = 1'b1;
    @(posedge clk); #1;
    start_u = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    sclr = 1'b1;
    @(posedge clk); #1;
    sclr = 1'b0;
    n_cmp++;
    if ({busy_u, valid_u, q_u} !== '0) begin
      n_fail++;
      $display("FAIL abort_clear: got busy=%b valid=%b q=%h, expected 0 0 000", busy_u, valid_u, q_u);
    end
    repeat (20) begin
      if (valid_u) seen++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_valid: got %0d valid cycles, expected 0", seen);
    end
    $display("abort checked, valid cycles after clear=%0d", seen);
    check_op("after_abort", 1'b0, 1'b0, 10'h090, 10'h030, 0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] held;
    check_op("b2b_first", 1'b0, 1'b0, 10'h090, 10'h030, 0);
    check_op("b2b_second", 1'b0, 1'b1, 10'h008, 10'h048, 0);
    check_op("b2b_dvz", 1'b0, 1'b1, 10'h055, 10'h000, 0);
    check_op("b2b_after_dvz", 1'b0, 1'b1, 10'h3FF, 10'h001, 0);
    held = q_u;
    @(posedge clk); #1;
    n_cmp++;
    if (valid_u !== 1'b0 || q_u !== held || ovf_u !== 1'b1) begin
      n_fail++;
      $display("FAIL hold: got valid=%b q=%h ovf=%b, expected valid=0 q=%h ovf=1", valid_u, q_u, ovf_u, held);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int i = 0; i < 60; i++) begin
      a = W'($urandom);
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = 10'h200;
        3: a = 10'h200;
        default: b = W'($urandom);
      endcase
      if ($urandom_range(0, 7) == 3) b = '0;
      else if (b == '0) b = 10'h001;
      check_op("random", i[0], ($urandom_range(0, 1) == 1) && (i > 1) && !i[0] == !(i - 1) ? 1'b0 : 1'b0, a, b, 0);
      check_op("random_b2b", i[0], 1'b1, W'($urandom), W'($urandom_range(1, 1023)), 0);
    end
  endtask

  initial begin
    sclr = 1'b1; start_u = 1'b0; start_s = 1'b0; data_a = '0; data_b = '0;
    test_reset();
    test_directed();
    test_signed();
    test_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/param_fixed_divider.md
Name: param_fixed_divider

Overview:
- Next-generation sequential fixed-point divider, parametrised in operand width, fractional bits and signedness.
- Computes q = (A << FRAC_BITS) / B using restoring division, one quotient bit per clock.
- Flags divide-by-zero (dvz) and overflow (ovf); saturates on overflow.
- Sits behind a start/busy/valid handshake as a shared arithmetic unit for datapath controllers.

Parameters:
WIDTH, 10, operand and quotient width in bits
FRAC_BITS, 4, fractional bits in operands and quotient (Q(WIDTH-FRAC_BITS).FRAC_BITS); range 0..WIDTH-1
SIGNED, 0, 0 = unsigned operands and result; 1 = two's-complement operands and result

Ports:
clk  input  1  system clock; all state updates on rising edge
sclr  input  1  synchronous clear, active-high; highest priority
start  input  1  request; sampled only while busy=0
data_a  input  WIDTH  dividend
data_b  input  WIDTH  divisor
valid  output  1  one-cycle pulse: q/ovf/dvz are fresh
ovf  output  1  quotient overflowed and was saturated
dvz  output  1  divisor was zero
busy  output  1  iteration in progress
q  output  WIDTH  quotient, truncated toward zero

Behaviour:
- Reset (sclr=1 at an edge): next cycle busy=0, valid=0, ovf=0, dvz=0, q=0.
  - Any in-flight division is aborted and no valid pulse is issued.
  - sclr overrides start in the same cycle.
- States:
  - IDLE -> (start & data_b==0) -> DONE: dvz path.
  - IDLE -> (start & data_b!=0) -> RUN.
  - RUN -> RUN for N = WIDTH+FRAC_BITS iterations, counter 0..N-1.
  - RUN -> DONE after the last iteration.
  - DONE -> IDLE after one cycle.
- Accept:
  - At edge k with start=1 & busy=0 (IDLE or DONE), latch the operands and clear ovf and dvz.
  - If SIGNED=1, latch magnitudes |A| and |B| (W-bit unsigned, so -2^(W-1) is representable) and sign = a[W-1]^b[W-1].
- Divide-by-zero:
  - valid=1, dvz=1, q=0, ovf=0 in the cycle after edge k.
  - busy never asserts.
- Normal division:
  - busy=1 for cycles k+1..k+N.
  - The internal dividend is {|A|, FRAC_BITS zeros}; the partial remainder is WIDTH+1 bits; the quotient register is N bits.
  - Cycle k+N+1: valid=1, busy=0.
  - Start-to-valid latency is N+1 cycles (15 with defaults).
- Overflow, unsigned:
  - Condition: full N-bit quotient >= 2^WIDTH.
  - Response: ovf=1, q = all ones.
- Overflow, signed:
  - Positive result: magnitude > 2^(W-1)-1 -> ovf=1, q = 2^(W-1)-1.
  - Negative result: magnitude > 2^(W-1) -> ovf=1, q = -2^(W-1).
  - Otherwise q = sign ? -mag : mag. A zero quotient is always +0.
- Holding and back-to-back operation:
  - q, ovf and dvz hold their value until the next accepted start; valid is high for exactly one cycle.
  - start while busy=1 is ignored, with no queuing.
  - start in the DONE cycle (busy=0) is accepted, giving back-to-back operation.
- data_a and data_b are don't-care except at the accept edge.

Test Plan:
(Defaults WIDTH=10, FRAC_BITS=4, SIGNED=0 unless stated.)
1. Normal division: start with A=0x090 (9.0), B=0x030 (3.0) -> busy high for 14 cycles; valid at cycle 15; q=0x030 (3.0); ovf=0; dvz=0.
2. Divide-by-zero: A=0x100, B=0x000 -> next cycle valid=1, dvz=1, q=0; busy stays 0.
3. Overflow: A=0x3FF, B=0x001 -> valid at cycle 15; ovf=1; q=0x3FF.
4. Fractional result: A=0x008, B=0x048 -> q=0x001 (128/72 truncated); ovf=0.
5. Abort and ignored start:
   - Start A=0x090, B=0x030, then pulse start again at iteration 3 with different data -> ignored.
   - sclr at iteration 5 -> next cycle busy=0, q=0, and no valid pulse follows.
   - A fresh start after that -> q=0x030 at cycle 15.
6. Signed mode (SIGNED=1):
   - A=0x3A0 (-6.0), B=0x030 (3.0) -> q=0x3E0 (-2.0), ovf=0.
   - A=0x200, B=0x3F0 (-1.0) -> ovf=1, q=0x1FF.
